// File: rtl/output_uart_tx.sv
// ---------------------------------------------------------------------------
// output_uart_tx
//   Serial sink for the A09 CPU output register. Every value the CPU writes
//   is queued in a small FIFO and sent as two 8N1 UART frames, high byte
//   first. The CPU is never stalled; words arriving at a full FIFO are
//   dropped and reported through a sticky flag.
//
// Ports
//   Clk       system clock (shared with the CPU)
//   Reset     synchronous, active-high reset
//   Load      CPU Output_Ld strobe (one cycle)
//   DIn       CPU OutReg value, valid the cycle after Load
//   Tx        UART serial line, idles high, driven from a flop
//   Busy      FIFO non-empty, frame in flight, or capture pending
//   Empty     FIFO holds no entries
//   Full      FIFO holds 2^FifoDepthLog2 entries
//   Overflow  sticky drop indicator, cleared only by Reset
// ---------------------------------------------------------------------------
module output_uart_tx #(
  parameter int DataWidth     = 16,
  parameter int ClkPerBit     = 104,
  parameter int FifoDepthLog2 = 2
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Load,
  input  logic [DataWidth-1:0] DIn,
  output logic                 Tx,
  output logic                 Busy,
  output logic                 Empty,
  output logic                 Full,
  output logic                 Overflow
);

  localparam int Depth = 1 << FifoDepthLog2;
  localparam int BaudW = (ClkPerBit > 1) ? $clog2(ClkPerBit) : 1;

  localparam logic [BaudW-1:0]         BaudLast = BaudW'(ClkPerBit - 1);
  localparam logic [BaudW-1:0]         BaudOne  = BaudW'(1);
  localparam logic [FifoDepthLog2-1:0] PtrOne   = FifoDepthLog2'(1);
  localparam logic [FifoDepthLog2:0]   CntOne   = (FifoDepthLog2 + 1)'(1);
  localparam logic [FifoDepthLog2:0]   CntFull  = (FifoDepthLog2 + 1)'(Depth);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } state_e;

  // FIFO storage and bookkeeping
  logic [DataWidth-1:0]     mem_q [Depth];
  logic [FifoDepthLog2-1:0] wr_ptr_q;
  logic [FifoDepthLog2-1:0] rd_ptr_q;
  logic [FifoDepthLog2:0]   count_q;
  logic [FifoDepthLog2:0]   count_d;
  logic                     load_q;
  logic                     overflow_q;

  // Transmitter
  state_e                   state_q;
  logic [DataWidth-1:0]     holding_q;
  logic [7:0]               shift_q;
  logic                     byte_sel_q;
  logic [2:0]               bit_cnt_q;
  logic [BaudW-1:0]         baud_q;
  logic                     tx_q;

  logic                     empty_s;
  logic                     full_s;
  logic                     pop_s;
  logic                     push_s;
  logic                     drop_s;
  logic [DataWidth-1:0]     head_s;

  assign empty_s = (count_q == '0);
  assign full_s  = (count_q == CntFull);
  assign head_s  = mem_q[rd_ptr_q];

  // FIFO handshake; a pop in the same cycle makes room for a write at full
  always_comb begin
    pop_s   = (state_q == StIdle) && !empty_s;
    push_s  = load_q && (!full_s || pop_s);
    drop_s  = load_q && full_s && !pop_s;
    count_d = count_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase
  end

  // FIFO storage array (contents are don't-care while the count is zero)
  always_ff @(posedge Clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= DIn;
    end
  end

  // Load delay, pointers, occupancy and the sticky overflow flag
  always_ff @(posedge Clk) begin
    if (Reset) begin
      load_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      // OutReg settles on the edge ending the Load cycle, so capture a cycle late
      load_q  <= Load;
      count_q <= count_d;
      if (push_s) begin
        wr_ptr_q <= wr_ptr_q + PtrOne;
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PtrOne;
      end
      if (drop_s) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Transmit FSM; tx_q is loaded with the level of the state being entered
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= StIdle;
      tx_q       <= 1'b1;
      holding_q  <= '0;
      shift_q    <= 8'h00;
      byte_sel_q <= 1'b0;
      bit_cnt_q  <= 3'd0;
      baud_q     <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          tx_q <= 1'b1;
          if (pop_s) begin
            holding_q  <= head_s;
            shift_q    <= head_s[DataWidth-1 -: 8];
            byte_sel_q <= 1'b0;
            bit_cnt_q  <= 3'd0;
            baud_q     <= '0;
            tx_q       <= 1'b0;
            state_q    <= StStart;
          end
        end
        StStart: begin
          if (baud_q == BaudLast) begin
            baud_q    <= '0;
            bit_cnt_q <= 3'd0;
            tx_q      <= shift_q[0];
            state_q   <= StData;
          end else begin
            baud_q <= baud_q + BaudOne;
          end
        end
        StData: begin
          if (baud_q == BaudLast) begin
            baud_q <= '0;
            if (bit_cnt_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= StStop;
            end else begin
              // Present the next bit now so the line is already correct after the shift
              shift_q   <= {1'b0, shift_q[7:1]};
              bit_cnt_q <= bit_cnt_q + 3'd1;
              tx_q      <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + BaudOne;
          end
        end
        StStop: begin
          if (baud_q == BaudLast) begin
            baud_q <= '0;
            if (!byte_sel_q) begin
              byte_sel_q <= 1'b1;
              shift_q    <= holding_q[7:0];
              tx_q       <= 1'b0;
              state_q    <= StStart;
            end else begin
              tx_q    <= 1'b1;
              state_q <= StIdle;
            end
          end else begin
            baud_q <= baud_q + BaudOne;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign Tx       = tx_q;
  assign Empty    = empty_s;
  assign Full     = full_s;
  assign Overflow = overflow_q;
  assign Busy     = (state_q != StIdle) | ~empty_s | load_q;

endmodule

// File: tb/tb_output_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_output_uart_tx
//   Directed bench for output_uart_tx with ClkPerBit=4, FifoDepthLog2=2.
//   A background UART decoder collects received bytes and start times.
// ---------------------------------------------------------------------------
module tb_output_uart_tx;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld;
  logic [15:0] din;
  logic        tx_w;
  logic        busy;
  logic        empty;
  logic        full;
  logic        ovf;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int lows  = 0;

  logic [7:0] rx_bytes [$];
  int         rx_start [$];
  logic       rx_stop  [$];

  // Expected line levels for 16'hA55A: start, A5 LSB first, stop, then 5A
  logic [0:19] exp_bits = 20'b0101001011_0010110101;

  output_uart_tx #(
    .DataWidth    (16),
    .ClkPerBit    (CPB),
    .FifoDepthLog2(2)
  ) dut (
    .Clk     (clk),
    .Reset   (rst),
    .Load    (ld),
    .DIn     (din),
    .Tx      (tx_w),
    .Busy    (busy),
    .Empty   (empty),
    .Full    (full),
    .Overflow(ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rx_at(input int i);
    if (i < rx_bytes.size()) return rx_bytes[i];
    else return 8'hxx;
  endfunction

  task automatic check_word(input string tag, input int idx, input logic [15:0] w);
    check($sformatf("%s_hi%0d", tag, idx), {24'd0, rx_at(2 * idx)}, {24'd0, w[15:8]});
    check($sformatf("%s_lo%0d", tag, idx), {24'd0, rx_at(2 * idx + 1)}, {24'd0, w[7:0]});
  endtask

  task automatic check_stops(input string tag);
    int bad = 0;
    foreach (rx_stop[i]) if (rx_stop[i] !== 1'b1) bad++;
    check(tag, bad, 32'd0);
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    int n = 0;
    while (busy !== 1'b0 && n < max_cyc) begin
      tick();
      n++;
    end
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic clear_rx();
    rx_bytes.delete();
    rx_start.delete();
    rx_stop.delete();
  endtask

  // Watch the line for n cycles and count any low level
  task automatic quiet_line(input string tag, input int n);
    lows = 0;
    for (int i = 0; i < n; i++) begin
      if (tx_w !== 1'b1) lows++;
      tick();
    end
    check(tag, lows, 32'd0);
  endtask

  // UART decoder: samples mid-bit, drops a frame if Reset is seen during it
  logic [7:0] mon_b;
  int         mon_s;
  logic       mon_stop;
  logic       mon_abort;

  initial begin : uart_monitor
    forever begin
      @(posedge clk);
      #2;
      if (rst === 1'b0 && tx_w === 1'b0) begin
        mon_s     = cyc;
        mon_abort = 1'b0;
        mon_b     = 8'h00;
        mon_stop  = 1'b0;
        for (int n = 1; n <= 38; n++) begin
          @(posedge clk);
          #2;
          if (rst !== 1'b0) mon_abort = 1'b1;
          if (n >= 6 && n <= 34 && ((n - 6) % 4) == 0) mon_b[(n - 6) / 4] = tx_w;
          if (n == 38) mon_stop = tx_w;
        end
        if (!mon_abort) begin
          rx_bytes.push_back(mon_b);
          rx_start.push_back(mon_s);
          rx_stop.push_back(mon_stop);
        end
      end
    end
  end

  int gap;

  initial begin : stimulus
    rst = 1'b1;
    ld  = 1'b0;
    din = 16'h0000;
    tick();
    tick();
    rst = 1'b0;

    // Reset values
    check("rst_tx",    {31'd0, tx_w},  32'd1);
    check("rst_busy",  {31'd0, busy},  32'd0);
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_full",  {31'd0, full},  32'd0);
    check("rst_ovf",   {31'd0, ovf},   32'd0);
    repeat (3) tick();

    // Single word 16'hA55A, cycle-exact line check
    clear_rx();
    ld = 1'b1;
    tick();                                   // k+1
    ld  = 1'b0;
    din = 16'hA55A;
    check("t2_empty_k1", {31'd0, empty}, 32'd1);
    check("t2_busy_k1",  {31'd0, busy},  32'd1);
    tick();                                   // k+2
    check("t2_empty_k2", {31'd0, empty}, 32'd0);
    check("t2_tx_k2",    {31'd0, tx_w},  32'd1);
    tick();                                   // k+3
    for (int i = 0; i < 80; i++) begin
      check($sformatf("t2_bit%0d", i), {31'd0, tx_w}, {31'd0, exp_bits[i / CPB]});
      check($sformatf("t2_busy%0d", i), {31'd0, busy}, 32'd1);
      tick();
    end
    check("t2_busy_end",  {31'd0, busy},  32'd0);
    check("t2_tx_end",    {31'd0, tx_w},  32'd1);
    check("t2_empty_end", {31'd0, empty}, 32'd1);
    check("t2_nbytes", rx_bytes.size(), 32'd2);
    check_word("t2", 0, 16'hA55A);
    repeat (5) tick();

    // Two words queued two cycles apart
    clear_rx();
    ld = 1'b1;
    tick();
    ld  = 1'b0;
    din = 16'h0001;
    tick();
    ld = 1'b1;
    tick();
    ld  = 1'b0;
    din = 16'hFFFF;
    tick();
    wait_idle("t3_idle", 400);
    check("t3_nbytes", rx_bytes.size(), 32'd4);
    check_word("t3", 0, 16'h0001);
    check_word("t3", 1, 16'hFFFF);
    check_stops("t3_stops");
    gap = (rx_bytes.size() >= 3) ? (rx_start[2] - (rx_start[1] + 10 * CPB)) : -1;
    check("t3_gap_le1", {31'd0, (gap >= 0 && gap <= 1)}, 32'd1);
    repeat (5) tick();

    // Six back-to-back loads into a 4-deep FIFO
    clear_rx();
    ld = 1'b1;
    tick();                                   // k+1
    din = 16'd1; tick();                      // k+2
    din = 16'd2; tick();                      // k+3
    din = 16'd3; tick();                      // k+4
    din = 16'd4; tick();                      // k+5
    din = 16'd5; tick();                      // k+6
    ld  = 1'b0;
    din = 16'd6;
    check("t4_full_k6", {31'd0, full}, 32'd1);
    check("t4_ovf_k6",  {31'd0, ovf},  32'd0);
    tick();                                   // k+7
    check("t4_ovf_k7",  {31'd0, ovf},  32'd1);
    check("t4_full_k7", {31'd0, full}, 32'd1);
    wait_idle("t4_idle", 800);
    repeat (20) tick();
    check("t4_nbytes", rx_bytes.size(), 32'd10);
    for (int w = 0; w < 5; w++) check_word("t4", w, 16'(w + 1));
    check_stops("t4_stops");
    check("t4_ovf_sticky", {31'd0, ovf}, 32'd1);

    // Reset mid-stream, with a Load raised during reset
    clear_rx();
    ld = 1'b1;
    tick();
    ld  = 1'b0;
    din = 16'h1234;
    tick();
    ld = 1'b1;
    tick();
    ld  = 1'b0;
    din = 16'h5678;
    tick();
    repeat (20) tick();
    rst = 1'b1;
    tick();
    ld = 1'b1;
    tick();
    rst = 1'b0;
    ld  = 1'b0;
    check("t1_tx",    {31'd0, tx_w},  32'd1);
    check("t1_empty", {31'd0, empty}, 32'd1);
    check("t1_busy",  {31'd0, busy},  32'd0);
    check("t1_ovf",   {31'd0, ovf},   32'd0);
    check("t1_full",  {31'd0, full},  32'd0);
    quiet_line("t1_quiet", 100);
    check("t1_nbytes", rx_bytes.size(), 32'd0);
    check("t1_empty_after", {31'd0, empty}, 32'd1);

    // Fill while busy, then land a write on the IDLE pop cycle
    clear_rx();
    ld = 1'b1;
    tick();                                   // j+1
    din = 16'h1111; tick();                   // j+2
    din = 16'h2222; tick();                   // j+3
    din = 16'h3333; tick();                   // j+4
    din = 16'h4444; tick();                   // j+5
    ld  = 1'b0;
    din = 16'h5555;
    tick();                                   // j+6
    check("t5_full_j6", {31'd0, full}, 32'd1);
    repeat (76) tick();                       // j+82
    check("t5_tx_stop", {31'd0, tx_w}, 32'd1);
    ld = 1'b1;
    tick();                                   // j+83
    ld  = 1'b0;
    din = 16'h6666;
    check("t5_full_j83", {31'd0, full}, 32'd1);
    tick();                                   // j+84
    check("t5_full_j84", {31'd0, full}, 32'd1);
    check("t5_ovf_j84",  {31'd0, ovf},  32'd0);
    check("t5_tx_start", {31'd0, tx_w}, 32'd0);
    wait_idle("t5_idle", 800);
    repeat (20) tick();
    check("t5_nbytes", rx_bytes.size(), 32'd12);
    check_word("t5", 0, 16'h1111);
    check_word("t5", 1, 16'h2222);
    check_word("t5", 2, 16'h3333);
    check_word("t5", 3, 16'h4444);
    check_word("t5", 4, 16'h5555);
    check_word("t5", 5, 16'h6666);
    check_stops("t5_stops");
    check("t5_ovf_end", {31'd0, ovf}, 32'd0);

    // Reset during data bit 3 of a frame, second word queued behind it
    clear_rx();
    ld = 1'b1;
    tick();                                   // k+1
    ld  = 1'b0;
    din = 16'h0000;
    tick();                                   // k+2
    ld = 1'b1;
    tick();                                   // k+3
    ld  = 1'b0;
    din = 16'h1234;
    tick();                                   // k+4
    repeat (15) tick();                       // k+19
    check("t6_tx_bit3",  {31'd0, tx_w},  32'd0);
    check("t6_empty_pre", {31'd0, empty}, 32'd0);
    tick();                                   // k+20
    rst = 1'b1;
    tick();                                   // k+21
    rst = 1'b0;
    check("t6_tx",    {31'd0, tx_w},  32'd1);
    check("t6_empty", {31'd0, empty}, 32'd1);
    check("t6_busy",  {31'd0, busy},  32'd0);
    quiet_line("t6_quiet", 100);
    check("t6_nbytes", rx_bytes.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
